mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Scan sequencer wrapped around the 8:1 channel mux: drives the mux select, samples the mux
//  output, and assembles one N_CH-bit word per scan, bit i = channel i. The word goes to the
//  consumer over a valid/ready handshake. Single-shot or continuous scanning.
// PARAMETERS
//  SEL_W  3  select width; N_CH = 1<<SEL_W channels (8 by default)
//  DWELL  2  cycles s is held per channel before/at sampling; legal 1..15
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  start       in   1      1-cycle pulse; begins a scan when IDLE, ignored otherwise
//  cont        in   1      1 = rescan automatically after each word is accepted
//  s           out  SEL_W  mux select, registered
//  y           in   1      mux output (combinational from s)
//  dout        out  N_CH   assembled word, stable while dout_valid=1
//  dout_valid  out  1      word available
//  dout_ready  in   1      consumer accepts word when valid&ready at clock edge
//  busy        out  1      1 in SCAN or HOLD
// BEHAVIOUR
//  Reset (rst_n=0 at edge): s=0, dout=0, dout_valid=0, busy=0, shift reg=0, dwell cnt=0,
//   state=IDLE. Overrides everything, incl. mid-scan (partial word discarded) and HOLD.
//  States: IDLE -> SCAN -> HOLD -> (SCAN if cont else IDLE).
//  IDLE: busy=0, s=0. start=1 -> SCAN, cnt=DWELL-1, s=0.
//  SCAN: busy=1. Each cycle cnt decrements; when cnt==0, y is sampled into word bit[s]
//   (same edge). Then if s==N_CH-1 -> HOLD, dout<=word with bit N_CH-1 = y, dout_valid<=1;
//   else s<=s+1, cnt<=DWELL-1. DWELL=1 samples every cycle.
//  Timing: start at edge k -> s=0 visible k+1; scan occupies N_CH*DWELL cycles; dout_valid
//   high from edge k+N_CH*DWELL. Default: valid 16 cycles after start edge.
//  HOLD: busy=1, dout/dout_valid stable until accepted; s held at N_CH-1.
//   valid&ready at edge -> dout_valid<=0 that edge; cont=1 -> SCAN (s=0, cnt=DWELL-1, no
//   idle gap); cont=0 -> IDLE. cont sampled only at acceptance.
//  dout keeps last accepted word after acceptance (not cleared) until the next word loads.
//  start during SCAN/HOLD: ignored, no queuing. dout_ready outside HOLD: ignored.
//  cont deasserted mid-scan: current scan completes and is delivered, then IDLE.
//  s wraps never: counts 0..N_CH-1 only, returns to 0 via state change.
//  No bubbles/no loss: a word is never overwritten before acceptance (scan stalls in HOLD).
// STRUCTURE
//  mux_scan_defs.vh: state encodings (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2), default SEL_W/DWELL.
//  Sub-module dwell_timer (4-bit down counter, load/zero flag) used for the dwell count.
//  FSM, select counter, shift/assembly register, output register in mux_scan_ctrl.
// TESTING (bench instantiates mux_scan_ctrl + 8:1 mux, mux in=8'b10110110)
//  1 DWELL=2, cont=0, ready=1, start pulse -> s steps 0..7 every 2 cycles; dout=8'hB6,
//    valid 1 cycle at start+16; returns to IDLE, busy=0.
//  2 ready held 0 for 10 cycles after valid -> dout=8'hB6 and valid stable all 10 cycles,
//    s stays 7; accepted on ready=1, valid low next cycle.
//  3 cont=1, ready=1, DWELL=1 -> back-to-back words 8'hB6 every 9 cycles (8 scan + 1 HOLD);
//    change mux in to 8'h5A mid-run -> next full scan word 8'h5A.
//  4 start pulses while busy -> no restart, s sequence unbroken, exactly one word.
//  5 rst_n=0 during SCAN at s=4 -> next cycle s=0, valid=0, busy=0, dout=0; fresh start
//    then produces correct 8'hB6.
//  6 rst_n=0 in HOLD with valid=1 -> valid=0, word dropped; no spurious valid afterward.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding and defaults.
package mux_scan_ctrl_pkg;

    // Sequencer states; the encodings are fixed so they read the same in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } scan_state_t;

    localparam int DEF_SEL_W   = 3;  // 8 channels
    localparam int DEF_DWELL   = 2;  // cycles per channel, legal 1..15
    localparam int DWELL_CNT_W = 4;  // wide enough for DWELL-1 up to 14

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Dwell timer: loadable down counter that stops at zero and flags it.
module mux_scan_ctrl_dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: load has priority over decrement; never wraps below zero.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around an N_CH:1 channel mux: steps the select, samples the mux
// output once per dwell period and hands one assembled word per scan to a
// valid/ready consumer. A pending word stalls the scan until it is accepted.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter  int SEL_W = DEF_SEL_W,
    parameter  int DWELL = DEF_DWELL,
    localparam int N_CH  = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    output logic [SEL_W-1:0] s,
    input  logic             y,
    output logic [N_CH-1:0]  dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy
);

    localparam logic [DWELL_CNT_W-1:0] DWELL_LD = DWELL_CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]       SEL_LAST = SEL_W'(N_CH - 1);

    scan_state_t      r_state;
    scan_state_t      w_next;
    logic [SEL_W-1:0] r_sel;
    logic [N_CH-1:0]  r_word;
    logic [N_CH-1:0]  r_dout;

    logic w_zero;    // dwell period ends this cycle
    logic w_last;    // select is on the final channel
    logic w_sample;  // capture y into the word at this edge
    logic w_load;    // restart the dwell timer
    logic w_dec;     // count the dwell timer down

    assign w_last   = (r_sel == SEL_LAST);
    assign w_sample = (r_state == ST_SCAN) && w_zero;

    mux_scan_ctrl_dwell_timer #(
        .CNT_W (DWELL_CNT_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (DWELL_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: a finished word parks in HOLD until the consumer takes it.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)               w_next = ST_SCAN;
            ST_SCAN: if (w_sample && w_last)  w_next = ST_HOLD;
            ST_HOLD: if (dout_ready)          w_next = cont ? ST_SCAN : ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    // Outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy       = 1'b0;
        dout_valid = 1'b0;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = start;
            end
            ST_SCAN: begin
                busy   = 1'b1;
                w_load = w_zero && !w_last;
                w_dec  = !w_zero;
            end
            ST_HOLD: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
                w_load     = dout_ready && cont;
            end
            default: ;
        endcase
    end

    // Select counter: 0 outside a scan, steps after each sample, parks on the last channel in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else begin
            case (r_state)
                ST_SCAN: if (w_sample && !w_last) r_sel <= r_sel + 1'b1;
                ST_HOLD: if (dout_ready)          r_sel <= '0;
                default:                          r_sel <= '0;
            endcase
        end
    end

    // Assembly register: bit i takes y while the select sits on channel i.
    always_ff @(posedge clk) begin
        // NOTE: this data register is reset on purpose so a scan cut short by reset leaves no stale bits.
        if (!rst_n) begin
            r_word <= '0;
        end else if (w_sample) begin
            r_word[r_sel] <= y;
        end
    end

    // Output register: loads once per scan, bypassing the last bit straight from y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_sample && w_last) begin
            r_dout <= {y, r_word[N_CH-2:0]};
        end
    end

    assign s    = r_sel;
    assign dout = r_dout;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1) driven by the same
// stimulus, each feeding its own 8:1 mux model, checked every cycle against an
// elapsed-time reference model plus directed scenario checks.
module tb_mux_scan_ctrl;

    localparam int N_CH   = 8;
    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       dout_ready;
    logic [7:0] mux_in;

    logic [2:0] s_o     [2];
    logic       y_i     [2];
    logic [7:0] dout_o  [2];
    logic       valid_o [2];
    logic       busy_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one per instance.
    int         dw     [2] = '{2, 1};
    int         m_mode [2];
    int         m_el   [2];
    logic [7:0] m_word [2];
    logic [7:0] m_dout [2];

    always #5 clk = ~clk;

    assign y_i[0] = mux_in[s_o[0]];
    assign y_i[1] = mux_in[s_o[1]];

    mux_scan_ctrl #(.SEL_W(3), .DWELL(2)) u_dut_d2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .s          (s_o[0]),
        .y          (y_i[0]),
        .dout       (dout_o[0]),
        .dout_valid (valid_o[0]),
        .dout_ready (dout_ready),
        .busy       (busy_o[0])
    );

    mux_scan_ctrl #(.SEL_W(3), .DWELL(1)) u_dut_d1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cont       (cont),
        .s          (s_o[1]),
        .y          (y_i[1]),
        .dout       (dout_o[1]),
        .dout_valid (valid_o[1]),
        .dout_ready (dout_ready),
        .busy       (busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs as they were before the edge.
    task automatic model_step();
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_mode[d] = M_IDLE;
                m_el[d]   = 0;
                m_word[d] = 8'h00;
                m_dout[d] = 8'h00;
            end else begin
                case (m_mode[d])
                    M_IDLE: if (start) begin
                        m_mode[d] = M_SCAN;
                        m_el[d]   = 0;
                    end
                    M_SCAN: begin
                        idx = m_el[d] / dw[d];
                        if (((m_el[d] + 1) % dw[d]) == 0) m_word[d][idx] = mux_in[idx];
                        if (m_el[d] + 1 == N_CH * dw[d]) begin
                            m_mode[d] = M_HOLD;
                            m_dout[d] = m_word[d];
                        end else begin
                            m_el[d] = m_el[d] + 1;
                        end
                    end
                    default: if (dout_ready) begin
                        m_mode[d] = cont ? M_SCAN : M_IDLE;
                        m_el[d]   = 0;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all();
        int exp_s;
        for (int d = 0; d < 2; d++) begin
            exp_s = (m_mode[d] == M_SCAN) ? m_el[d] / dw[d] :
                    (m_mode[d] == M_HOLD) ? N_CH - 1 : 0;
            check($sformatf("model%0d_s", d),     32'(s_o[d]),     32'(exp_s));
            check($sformatf("model%0d_valid", d), 32'(valid_o[d]), 32'(m_mode[d] == M_HOLD));
            check($sformatf("model%0d_busy", d),  32'(busy_o[d]),  32'(m_mode[d] != M_IDLE));
            check($sformatf("model%0d_dout", d),  32'(dout_o[d]),  32'(m_dout[d]));
        end
    endtask

    // One clock: model follows the edge, DUT outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (busy_o[0] || busy_o[1]); i++) tick();
        check("drain_busy_d2", 32'(busy_o[0]), 32'd0);
        check("drain_busy_d1", 32'(busy_o[1]), 32'd0);
    endtask

    initial begin
        int n_words;

        rst_n      = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        dout_ready = 1'b1;
        mux_in     = 8'hB6;
        tick();
        tick();
        check("rst_s",     32'(s_o[0]),     32'd0);
        check("rst_valid", 32'(valid_o[0]), 32'd0);
        check("rst_busy",  32'(busy_o[0]),  32'd0);
        check("rst_dout",  32'(dout_o[0]),  32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single shot, DWELL=2, consumer always ready.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s1_first_sel", 32'(s_o[0]), 32'd0);
        for (int j = 1; j <= 17; j++) begin
            tick();
            if (j < 16) check("s1_sel_step", 32'(s_o[0]), 32'(j / 2));
            if (j == 15) check("s1_not_yet_valid", 32'(valid_o[0]), 32'd0);
            if (j == 16) begin
                check("s1_valid", 32'(valid_o[0]), 32'd1);
                check("s1_dout",  32'(dout_o[0]),  32'hB6);
                check("s1_sel7",  32'(s_o[0]),     32'd7);
            end
            if (j == 17) begin
                check("s1_valid_drop", 32'(valid_o[0]), 32'd0);
                check("s1_idle",       32'(busy_o[0]),  32'd0);
            end
        end

        // 2: consumer stalls for 10 cycles.
        dout_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 16; j++) tick();
        check("s2_valid", 32'(valid_o[0]), 32'd1);
        for (int j = 0; j < 10; j++) begin
            tick();
            check("s2_hold_valid", 32'(valid_o[0]), 32'd1);
            check("s2_hold_dout",  32'(dout_o[0]),  32'hB6);
            check("s2_hold_sel",   32'(s_o[0]),     32'd7);
        end
        dout_ready = 1'b1;
        tick();
        check("s2_accepted",  32'(valid_o[0]), 32'd0);
        check("s2_dout_kept", 32'(dout_o[0]),  32'hB6);
        drain();

        // 3: continuous, DWELL=1 instance; data changes mid-run.
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start   = 1'b0;
        n_words = 0;
        for (int t = 1; t <= 36; t++) begin
            tick();
            if (valid_o[1]) begin
                check("s3_period", 32'(t), 32'(8 + 9 * n_words));
                if (n_words < 2)  check("s3_word_b6", 32'(dout_o[1]), 32'hB6);
                if (n_words == 3) check("s3_word_5a", 32'(dout_o[1]), 32'h5A);
                n_words++;
            end
            if (t == 20) mux_in = 8'h5A;
        end
        check("s3_word_count", 32'(n_words), 32'd4);
        cont = 1'b0;
        drain();

        // 4: start pulses while busy are ignored.
        mux_in = 8'hB6;
        start  = 1'b1;
        tick();
        n_words = 0;
        for (int t = 1; t <= 30; t++) begin
            start = (t < 15 && (t % 3) == 0);
            tick();
            if (t < 16) check("s4_sel_seq", 32'(s_o[0]), 32'(t / 2));
            if (valid_o[0]) n_words++;
        end
        start = 1'b0;
        check("s4_one_word", 32'(n_words), 32'd1);
        drain();

        // 5: reset in the middle of a scan.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 8; j++) tick();
        check("s5_at_sel4", 32'(s_o[0]), 32'd4);
        rst_n = 1'b0;
        tick();
        check("s5_rst_sel",   32'(s_o[0]),     32'd0);
        check("s5_rst_valid", 32'(valid_o[0]), 32'd0);
        check("s5_rst_busy",  32'(busy_o[0]),  32'd0);
        check("s5_rst_dout",  32'(dout_o[0]),  32'd0);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 16; j++) tick();
        check("s5_fresh_valid", 32'(valid_o[0]), 32'd1);
        check("s5_fresh_dout",  32'(dout_o[0]),  32'hB6);
        drain();

        // 6: reset while a word is waiting.
        dout_ready = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 16; j++) tick();
        check("s6_valid", 32'(valid_o[0]), 32'd1);
        rst_n = 1'b0;
        tick();
        check("s6_dropped", 32'(valid_o[0]), 32'd0);
        rst_n   = 1'b1;
        n_words = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (valid_o[0] || valid_o[1]) n_words++;
        end
        check("s6_no_spurious", 32'(n_words), 32'd0);
        dout_ready = 1'b1;

        // Randomized traffic checked against the model.
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(7) == 0);
            dout_ready = 1'($urandom_range(1));
            if ($urandom_range(63) == 0) cont = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) mux_in = 8'($urandom);
            rst_n = ($urandom_range(499) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
